// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a load handshake.
// Handshake: a word transfers on a rising edge where load_valid && load_ready;
// load_ready is combinational and may rise in the same cycle that the
// current word retires, so back-to-back words stream with no idle gap.
// sr_out / sr_first / sr_last are registered together, so there is no skew
// between a bit and its framing flags. busy is the FSM state (SHIFT) itself.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sr_out,
    output logic             sr_valid,
    output logic             sr_first,
    output logic             sr_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sr_out_q, sr_out_d;
    logic             sr_first_q, sr_first_d;
    logic             sr_last_q, sr_last_d;
    logic             done_q, done_d;
    logic             retire;
    logic             load_fire;

    // Next-state, datapath and handshake decode. shreg holds the bits that
    // still have to follow the one currently on sr_out.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        sr_out_d   = sr_out_q;
        sr_first_d = sr_first_q;
        sr_last_d  = sr_last_q;
        done_d     = 1'b0;

        retire     = (state_q == S_SHIFT) && shift_en && (cnt_q == LAST_CNT);
        load_ready = rst && ((state_q == S_IDLE) || retire);
        load_fire  = load_valid && load_ready;

        case (state_q)
            S_IDLE: begin
                sr_out_d   = 1'b0;
                sr_first_d = 1'b0;
                sr_last_d  = 1'b0;
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == LAST_CNT) begin
                        // Word retires; fall back to idle unless a reload follows.
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                        cnt_d      = '0;
                        shreg_d    = '0;
                        sr_out_d   = 1'b0;
                        sr_first_d = 1'b0;
                        sr_last_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        sr_first_d = 1'b0;
                        sr_last_d  = ((cnt_q + 1'b1) == LAST_CNT);
                        if (MSB_FIRST) begin
                            sr_out_d = shreg_q[WIDTH-1];
                            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            sr_out_d = shreg_q[0];
                            shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted load overrides the idle/retire path above.
        if (load_fire) begin
            state_d    = S_SHIFT;
            cnt_d      = '0;
            sr_first_d = 1'b1;
            sr_last_d  = 1'b0;
            if (MSB_FIRST) begin
                sr_out_d = par_in[WIDTH-1];
                shreg_d  = {par_in[WIDTH-2:0], 1'b0};
            end else begin
                sr_out_d = par_in[0];
                shreg_d  = {1'b0, par_in[WIDTH-1:1]};
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            sr_out_q   <= 1'b0;
            sr_first_q <= 1'b0;
            sr_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            sr_out_q   <= sr_out_d;
            sr_first_q <= sr_first_d;
            sr_last_q  <= sr_last_d;
            done_q     <= done_d;
        end
    end

    assign sr_out   = sr_out_q;
    assign sr_first = sr_first_q;
    assign sr_last  = sr_last_q;
    assign sr_valid = (state_q == S_SHIFT);
    assign busy     = (state_q == S_SHIFT);
    assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// all inputs. Expected {bit, first, last} triples are queued when a load is
// driven and consumed by a per-cycle monitor; scenario tasks check timing,
// handshake and framing inline.
module tb_piso_serializer;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] par_in;
    logic         load_valid;
    logic         shift_en;

    logic m_ready, m_out, m_valid, m_first, m_last, m_busy, m_done;
    logic l_ready, l_out, l_valid, l_first, l_last, l_busy, l_done;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
        .load_ready(m_ready), .shift_en(shift_en), .sr_out(m_out),
        .sr_valid(m_valid), .sr_first(m_first), .sr_last(m_last),
        .busy(m_busy), .done(m_done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
        .load_ready(l_ready), .shift_en(shift_en), .sr_out(l_out),
        .sr_valid(l_valid), .sr_first(l_first), .sr_last(l_last),
        .busy(l_busy), .done(l_done)
    );

    // ---------------- scoreboard ----------------
    logic [2:0] exp_m_q[$];
    logic [2:0] exp_l_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_m_q.push_back({w[W-1-i], (i == 0), (i == W-1)});
            exp_l_q.push_back({w[i], (i == 0), (i == W-1)});
        end
    endtask

    // Runs 1 time unit after each falling edge so inputs for the coming edge
    // are settled; a bit is consumed only if the next edge shifts it out.
    task automatic mon_step();
        if (m_valid === 1'b1) begin
            n_checks++;
            if (exp_m_q.size() == 0)
                $display("FAIL mon_msb: got out=%b with no expected bit", m_out);
            else if ({m_out, m_first, m_last} !== exp_m_q[0])
                $display("FAIL mon_msb: got out/first/last=%b want %b", {m_out, m_first, m_last}, exp_m_q[0]);
            else
                n_pass++;
            if (shift_en && rst && exp_m_q.size() > 0) void'(exp_m_q.pop_front());
        end
        if (l_valid === 1'b1) begin
            n_checks++;
            if (exp_l_q.size() == 0)
                $display("FAIL mon_lsb: got out=%b with no expected bit", l_out);
            else if ({l_out, l_first, l_last} !== exp_l_q[0])
                $display("FAIL mon_lsb: got out/first/last=%b want %b", {l_out, l_first, l_last}, exp_l_q[0]);
            else
                n_pass++;
            if (shift_en && rst && exp_l_q.size() > 0) void'(exp_l_q.pop_front());
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (m_busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b1; par_in = 8'hFF; shift_en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_ready, m_out, m_valid, m_first, m_last, m_busy, m_done,
             l_ready, l_out, l_valid, l_busy, l_done} !== 12'h000)
            $display("FAIL reset_outputs: got %b want all 0",
                     {m_ready, m_out, m_valid, m_first, m_last, m_busy, m_done,
                      l_ready, l_out, l_valid, l_busy, l_done});
        else n_pass++;
        load_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_ready, m_valid, m_busy} !== 3'b100)
            $display("FAIL reset_release: ready/valid/busy got %b want 100", {m_ready, m_valid, m_busy});
        else n_pass++;
    endtask

    // Starts at a falling edge with the block idle; ends at cycle 10.
    task automatic test_single(input logic [W-1:0] w);
        n_checks++;
        if (m_ready !== 1'b1) $display("FAIL single_ready: got %b want 1 (word %h)", m_ready, w);
        else n_pass++;
        par_in = w; load_valid = 1'b1; push_word(w);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (c == 1) begin load_valid = 1'b0; par_in = W'($urandom); end
            n_checks++;
            if ({m_valid, m_busy, m_done, l_valid} !== 4'b1101)
                $display("FAIL single_cycle%0d: valid/busy/done/lvalid got %b want 1101", c, {m_valid, m_busy, m_done, l_valid});
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({m_valid, m_busy, m_done, l_done} !== 4'b0011)
            $display("FAIL single_done: valid/busy/done/ldone got %b want 0011 (word %h)", {m_valid, m_busy, m_done, l_done}, w);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({m_done, exp_m_q.size() == 0, exp_l_q.size() == 0} !== 3'b011)
            $display("FAIL single_end: done/msb_q_empty/lsb_q_empty got %b want 011", {m_done, exp_m_q.size() == 0, exp_l_q.size() == 0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        par_in = 8'hA5; load_valid = 1'b1; push_word(8'hA5);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (c == 1) par_in = 8'h3C;
            n_checks++;
            if (m_ready !== (c == W)) $display("FAIL b2b_ready%0d: got %b want %b", c, m_ready, (c == W));
            else n_pass++;
            if (c == W) push_word(8'h3C);
        end
        @(negedge clk);
        load_valid = 1'b0;
        n_checks++;
        if ({m_valid, m_first, m_done} !== 3'b111)
            $display("FAIL b2b_cycle9: valid/first/done got %b want 111", {m_valid, m_first, m_done});
        else n_pass++;
        for (int c = 10; c <= 16; c++) begin
            @(negedge clk);
            n_checks++;
            if ({m_valid, m_done} !== 2'b10) $display("FAIL b2b_cycle%0d: valid/done got %b want 10", c, {m_valid, m_done});
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({m_valid, m_done, exp_m_q.size() == 0, exp_l_q.size() == 0} !== 4'b0111)
            $display("FAIL b2b_cycle17: valid/done/q_empty got %b want 0111", {m_valid, m_done, exp_m_q.size() == 0, exp_l_q.size() == 0});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int n_valid = 0;
        par_in = 8'hF0; load_valid = 1'b1; push_word(8'hF0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) load_valid = 1'b0;
            if (m_valid === 1'b1) n_valid++;
            if (c >= 5 && c <= 7) begin
                load_valid = 1'b1;
                n_checks++;
                if ({m_ready, l_ready, m_done} !== 3'b000)
                    $display("FAIL stall_ready%0d: ready/lready/done got %b want 000", c, {m_ready, l_ready, m_done});
                else n_pass++;
                load_valid = 1'b0;
            end
            if (c == 4) shift_en = 1'b0;
            if (c == 7) shift_en = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (n_valid !== 11 || {m_valid, m_done} !== 2'b01 || exp_m_q.size() != 0)
            $display("FAIL stall_total: valid_cycles=%0d valid/done=%b left=%0d want 11/01/0", n_valid, {m_valid, m_done}, exp_m_q.size());
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_load_while_busy();
        int n;
        par_in = 8'h00; load_valid = 1'b1; push_word(8'h00);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (c == 1) load_valid = 1'b0;
            if (c == 3) begin par_in = 8'hFF; load_valid = 1'b1; end
            if (c >= 3) begin
                n_checks++;
                if (m_ready !== (c == W)) $display("FAIL busy_ready%0d: got %b want %b", c, m_ready, (c == W));
                else n_pass++;
            end
            if (c == W) push_word(8'hFF);
        end
        @(negedge clk);
        load_valid = 1'b0;
        n_checks++;
        if ({m_valid, m_first, m_done} !== 3'b111)
            $display("FAIL busy_reload: valid/first/done got %b want 111", {m_valid, m_first, m_done});
        else n_pass++;
        drain(n);
        n_checks++;
        if (n !== 8 || m_done !== 1'b1 || exp_m_q.size() != 0 || exp_l_q.size() != 0)
            $display("FAIL busy_drain: cycles=%0d done=%b left=%0d want 8/1/0", n, m_done, exp_m_q.size());
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        par_in = 8'hC3; load_valid = 1'b1; push_word(8'hC3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) load_valid = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_ready, m_out, m_valid, m_first, m_last, m_busy, m_done, l_valid, l_done} !== 9'h000)
            $display("FAIL midrst_outputs: got %b want all 0",
                     {m_ready, m_out, m_valid, m_first, m_last, m_busy, m_done, l_valid, l_done});
        else n_pass++;
        n_checks++;
        if (exp_m_q.size() != 4) $display("FAIL midrst_bits_left: got %0d want 4", exp_m_q.size());
        else n_pass++;
        exp_m_q.delete();
        exp_l_q.delete();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_done, m_valid, m_ready} !== 3'b001)
            $display("FAIL midrst_release: done/valid/ready got %b want 001", {m_done, m_valid, m_ready});
        else n_pass++;
        test_single(8'h81);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; par_in = '0; load_valid = 1'b0; shift_en = 1'b1;
        fork
            forever begin
                @(negedge clk);
                #1;
                mon_step();
            end
        join_none
        @(negedge clk);
        test_reset();
        test_single(8'hA5);
        test_single(8'h0F);
        test_single(W'($urandom_range(0, 255)));
        test_back_to_back();
        test_stall();
        test_load_while_busy();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
